// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS IF stage: PC, imem request/response handshake, response queue, IF/ID register
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_d,
    input  logic        redirect_d,
    input  logic [31:0] redirect_pc_d,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pcplus4_d,
    output logic        valid_d
);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [CW:0] QD = (CW + 1)'(QDEPTH);

    logic [CW-1:0] outstanding, discard, count, out_next;
    logic [PW-1:0] q_head, q_tail, t_head, t_tail;
    logic [31:0]   q_instr [QDEPTH];
    logic [31:0]   q_pc4   [QDEPTH];
    logic [31:0]   tag_pc4 [QDEPTH];
    logic          run;
    logic          gnt_fire, rsp_fire, rsp_acc, redir, if_load, q_push, q_pop;
    logic          unused_low_bits;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Outstanding requests and queued entries together never exceed QDEPTH,
    // which is what keeps the response queue from overflowing during stalls.
    assign imem_req  = run && (({1'b0, outstanding} + {1'b0, count}) < QD);
    assign imem_addr = pc_f;

    assign gnt_fire = imem_req && imem_gnt;
    assign rsp_fire = imem_rvalid && (outstanding != '0);
    assign rsp_acc  = rsp_fire && (discard == '0);
    assign redir    = redirect_d && !stall_d;
    assign if_load  = !stall_d && !redir;
    assign q_pop    = if_load && (count != '0);
    assign q_push   = rsp_acc && !redir && !(if_load && (count == '0));
    assign out_next = outstanding + CW'(gnt_fire) - CW'(rsp_fire);

    assign unused_low_bits = ^redirect_pc_d[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run         <= 1'b0;
            pc_f        <= {RESET_PC[31:2], 2'b00};
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            q_head      <= '0;
            q_tail      <= '0;
            t_head      <= '0;
            t_tail      <= '0;
            instr_d     <= NOP;
            pcplus4_d   <= 32'h0;
            valid_d     <= 1'b0;
        end else begin
            run         <= 1'b1;
            outstanding <= out_next;
            if (gnt_fire) t_tail <= ptr_inc(t_tail);
            if (rsp_fire) t_head <= ptr_inc(t_head);
            if (redir) begin
                // Everything still in flight, including this cycle's grant, is stale.
                pc_f    <= {redirect_pc_d[31:2], 2'b00};
                discard <= out_next;
                count   <= '0;
                q_head  <= '0;
                q_tail  <= '0;
                instr_d <= NOP;
                valid_d <= 1'b0;
            end else begin
                if (gnt_fire) pc_f <= pc_f + 32'd4;
                if (rsp_fire && (discard != '0)) discard <= discard - CW'(1);
                if (q_push) q_tail <= ptr_inc(q_tail);
                if (q_pop) q_head <= ptr_inc(q_head);
                count <= count + CW'(q_push) - CW'(q_pop);
                if (if_load) begin
                    if (count != '0) begin
                        instr_d   <= q_instr[q_head];
                        pcplus4_d <= q_pc4[q_head];
                        valid_d   <= 1'b1;
                    end else if (rsp_acc) begin
                        instr_d   <= imem_rdata;
                        pcplus4_d <= tag_pc4[t_head];
                        valid_d   <= 1'b1;
                    end else begin
                        instr_d <= NOP;
                        valid_d <= 1'b0;
                    end
                end
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (gnt_fire) tag_pc4[t_tail] <= pc_f + 32'd4;
        if (q_push) begin
            q_instr[q_tail] <= imem_rdata;
            q_pc4[q_tail]   <= tag_pc4[t_head];
        end
    end
endmodule
